// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the matrix keypad scanner.
// Scan-state encoding, key event bundle and width helper.
package keypad_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    SAMPLE = 1'b1
  } scan_state_e;

  localparam int KP_CODE_W = 8;

  typedef struct packed {
    logic [KP_CODE_W-1:0] code;
    logic                 rel;
  } kp_event_t;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// kp_event_fifo: first-word-fall-through event queue.
// A push into a full queue is taken when a pop happens on the same edge.
module kp_event_fifo
  import keypad_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);
  localparam int NW = clog2(DEPTH + 1);
  localparam logic [NW-1:0] FULL_N = NW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [NW-1:0] count;
  logic [W-1:0]  last_q;
  logic          pop;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_N);
  assign pop     = ready && !empty;
  assign push_ok = push && (!full || pop);

  // Head stays frozen on the last shown entry once drained.
  assign dout = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (!empty) last_q <= mem[rd_ptr];
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: ROWS x COLS matrix scan with per-key debounce.
// Press/release events leave through a valid/ready FWFT queue.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYC     = 8,
  parameter int DEB_FRAMES     = 4,
  parameter int DEPTH          = 8,
  parameter int REPORT_RELEASE = 1,
  localparam int CW            = clog2(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 Rst,
  output logic [COLS-1:0]      col_o,
  input  logic [ROWS-1:0]      row_i,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [CW-1:0]        ev_code,
  output logic                 ev_release,
  output logic [ROWS*COLS-1:0] held,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam int K   = ROWS * COLS;
  localparam int RW  = clog2(ROWS);
  localparam int CCW = clog2(COLS);
  localparam int PW  = clog2((SETTLE_CYC > ROWS) ? SETTLE_CYC : ROWS);
  localparam int DCW = clog2(DEB_FRAMES);

  localparam logic [PW-1:0]  SETTLE_LAST = PW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0]  ROW_LAST    = PW'(ROWS - 1);
  localparam logic [CCW-1:0] COL_LAST    = CCW'(COLS - 1);
  localparam logic [DCW-1:0] DEB_LAST    = DCW'(DEB_FRAMES - 1);

  logic [ROWS-1:0] row_s1;
  logic [ROWS-1:0] row_s2;

  scan_state_e     state;
  logic [CCW-1:0]  col;
  logic [PW-1:0]   cnt;

  logic [RW-1:0]   row_idx;
  logic [CW-1:0]   key;
  logic            sampling;
  logic            key_down;
  logic            cur_held;
  logic            differs;
  logic            flip;
  logic            ev_push;

  logic [DCW-1:0]  deb_cnt [K];
  logic [K-1:0]    held_q;

  kp_event_t       ev_in;
  kp_event_t       head;
  logic            full;
  logic            empty;
  logic            drop;
  logic            unused_code;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_i;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state <= SETTLE;
      col   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= SAMPLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (cnt == ROW_LAST) begin
            state <= SETTLE;
            cnt   <= '0;
            col   <= (col == COL_LAST) ? '0 : col + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    col_o      = '1;
    col_o[col] = 1'b0;
  end

  // One key per SAMPLE cycle: the row index is the phase counter.
  assign sampling = (state == SAMPLE);
  assign row_idx  = cnt[RW-1:0];
  assign key      = CW'(32'(row_idx) * COLS + 32'(col));
  assign key_down = ~row_s2[row_idx];
  assign cur_held = held_q[key];
  assign differs  = sampling && (key_down != cur_held);
  assign flip     = differs && (deb_cnt[key] == DEB_LAST);
  assign ev_push  = flip && (!cur_held || (REPORT_RELEASE != 0));

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      held_q <= '0;
      for (int i = 0; i < K; i++) deb_cnt[i] <= '0;
    end else if (sampling) begin
      if (!differs) begin
        deb_cnt[key] <= '0;
      end else if (flip) begin
        deb_cnt[key] <= '0;
        held_q[key]  <= ~cur_held;
      end else begin
        deb_cnt[key] <= deb_cnt[key] + 1'b1;
      end
    end
  end

  always_comb begin
    ev_in.code = KP_CODE_W'(key);
    ev_in.rel  = cur_held;
  end

  kp_event_fifo #(
    .W     ($bits(kp_event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (Rst),
    .push  (ev_push),
    .din   (ev_in),
    .ready (ev_ready),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign ev_valid    = !empty;
  assign ev_code     = head.code[CW-1:0];
  assign ev_release  = head.rel;
  assign held        = held_q;
  assign unused_code = ^head.code;

  assign drop = ev_push && full && !(ev_valid && ev_ready);

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-arithmetic model plus directed key scenarios.
// A second instance covers the presses-only configuration.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic        started;
  logic [15:0] keys;

  logic [3:0]  col, col0;
  logic [3:0]  row, row0;
  logic        ev_valid, ev_valid0;
  logic        ev_ready;
  logic        ev_ready0;
  logic [3:0]  ev_code, ev_code0;
  logic        ev_release, ev_release0;
  logic [15:0] held, held0;
  logic        overflow, overflow0;
  logic        clr_overflow;

  int checks;
  int failures;

  logic [4:0] log1[$];
  logic [4:0] log0[$];

  int         mn;
  logic [15:0] mheld, k1, k2;
  int         mcnt [16];
  logic [4:0] mq[$];
  logic [4:0] mlast;
  logic       mov;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SETTLE_CYC(2), .DEB_FRAMES(3),
    .DEPTH(4), .REPORT_RELEASE(1)
  ) dut (
    .clk(clk), .Rst(rst), .col_o(col), .row_i(row),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_release(ev_release), .held(held), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SETTLE_CYC(2), .DEB_FRAMES(3),
    .DEPTH(4), .REPORT_RELEASE(0)
  ) dut0 (
    .clk(clk), .Rst(rst), .col_o(col0), .row_i(row0),
    .ev_valid(ev_valid0), .ev_ready(ev_ready0), .ev_code(ev_code0),
    .ev_release(ev_release0), .held(held0), .overflow(overflow0),
    .clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ev_ready0 = 1'b1;

  // Switch matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row  = '1;
    row0 = '1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
        if (!col0[c] && keys[r*4+c]) row0[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: frame position from cycle count; sample lags the pins by 2 cycles.
  initial begin : model
    int p, c, o, k;
    logic [4:0] ev;
    logic pop, gen, drop;
    mn = 0; mheld = '0; k1 = '0; k2 = '0; mlast = '0; mov = 1'b0;
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mn = 0; mheld = '0; k1 = '0; k2 = '0; mlast = '0; mov = 1'b0;
        for (int i = 0; i < 16; i++) mcnt[i] = 0;
        mq.delete();
      end else begin
        p = mn % 24;
        c = p / 6;
        o = p % 6;
        pop = (mq.size() != 0) && ev_ready;
        gen = 1'b0;
        drop = 1'b0;
        ev = '0;
        if (o >= 2) begin
          k = (o - 2) * 4 + c;
          if (k2[k] == mheld[k]) begin
            mcnt[k] = 0;
          end else begin
            mcnt[k] = mcnt[k] + 1;
            if (mcnt[k] == 3) begin
              gen = 1'b1;
              ev = {mheld[k], 4'(k)};
              mheld[k] = ~mheld[k];
              mcnt[k] = 0;
            end
          end
        end
        if (pop) mlast = mq.pop_front();
        if (gen) begin
          if (mq.size() < 4) mq.push_back(ev);
          else drop = 1'b1;
        end
        if (drop) mov = 1'b1;
        else if (clr_overflow) mov = 1'b0;
        k2 = k1;
        k1 = keys;
        mn = mn + 1;
      end
    end
  end

  initial begin : compare
    logic [3:0] ecol;
    logic [4:0] hd;
    forever begin
      @(negedge clk);
      if (started) begin
        ecol = ~(4'b0001 << ((mn % 24) / 6));
        hd = (mq.size() != 0) ? mq[0] : mlast;
        chk("col_o", 32'(col), 32'(ecol));
        chk("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
        chk("ev_code", 32'(ev_code), 32'(hd[3:0]));
        chk("ev_release", 32'(ev_release), 32'(hd[4]));
        chk("held", 32'(held), 32'(mheld));
        chk("overflow", 32'(overflow), 32'(mov));
        chk("held_norel", 32'(held0), 32'(mheld));
        if (!rst && ev_valid && ev_ready)
          log1.push_back({ev_release, ev_code});
        if (!rst && ev_valid0 && ev_ready0)
          log0.push_back({ev_release0, ev_code0});
      end
    end
  end

  task automatic do_reset(input logic [15:0] k);
    @(posedge clk);
    #2;
    rst = 1'b1;
    keys = k;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    log1.delete();
    log0.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_log(input string nm, input int which, input int idx,
                         input logic [4:0] exp);
    logic [31:0] act;
    act = 32'hdead;
    if (which == 1 && idx < log1.size()) act = 32'(log1[idx]);
    if (which == 0 && idx < log0.size()) act = 32'(log0[idx]);
    chk(nm, act, 32'(exp));
  endtask

  task automatic drain;
    ev_ready = 1'b1;
    for (int i = 0; i < 40 && ev_valid; i++) wait_cyc(1);
    chk("drain_done", 32'(ev_valid), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; started = 1'b0; keys = '0;
    ev_ready = 1'b1; clr_overflow = 1'b0;

    // Single press/release of key 6, both configurations.
    do_reset(16'h0040);
    wait_cyc(96);
    chk("press_held", 32'(held), 32'h0040);
    chk("press_len", 32'(log1.size()), 32'd1);
    chk_log("press_ev", 1, 0, 5'h06);
    keys = '0;
    wait_cyc(96);
    chk("rel_held", 32'(held), 32'h0000);
    chk("rel_len", 32'(log1.size()), 32'd2);
    chk_log("rel_ev", 1, 1, 5'h16);
    chk("norel_len", 32'(log0.size()), 32'd1);
    chk_log("norel_ev", 0, 0, 5'h06);
    chk("norel_held", 32'(held0), 32'h0000);

    // Rollover of keys 0 and 15, then reset mid-frame.
    do_reset(16'h8001);
    wait_cyc(96);
    chk("roll_len", 32'(log1.size()), 32'd2);
    chk_log("roll_ev0", 1, 0, 5'h00);
    chk_log("roll_ev1", 1, 1, 5'h0f);
    chk("roll_held", 32'(held), 32'h8001);
    wait_cyc(10);
    rst = 1'b1;
    #1;
    chk("rst_col", 32'(col), 32'h0000000e);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_held", 32'(held), 32'h0000);
    keys = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_cyc(5);
    chk("restart_col0", 32'(col), 32'h0000000e);
    wait_cyc(1);
    chk("restart_col1", 32'(col), 32'h0000000d);

    // Bounce: 2 frames down, 1 frame up, never reaches the threshold.
    do_reset(16'h0000);
    for (int i = 0; i < 3; i++) begin
      keys = 16'h0040;
      wait_cyc(48);
      keys = '0;
      wait_cyc(24);
    end
    wait_cyc(24);
    chk("bounce_len", 32'(log1.size()), 32'd0);
    chk("bounce_held", 32'(held), 32'h0000);

    // Overflow: five presses into a four-entry queue with no consumer.
    ev_ready = 1'b0;
    do_reset(16'h0000);
    for (int i = 1; i <= 5; i++) begin
      keys = keys | (16'h0001 << i);
      wait_cyc(96);
    end
    chk("ovf_valid", 32'(ev_valid), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(ev_code), 32'd1);
    chk("ovf_held", 32'(held), 32'h003e);
    clr_overflow = 1'b1;
    wait_cyc(1);
    clr_overflow = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    drain();
    chk("ovf_len", 32'(log1.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_log("ovf_ev", 1, i, 5'(i + 1));

    // Full queue with a pop on the edge a fifth event arrives.
    ev_ready = 1'b0;
    do_reset(16'h009e);
    wait_cyc(69);
    ev_ready = 1'b1;
    wait_cyc(1);
    ev_ready = 1'b0;
    chk("fullpop_valid", 32'(ev_valid), 32'd1);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_head", 32'(ev_code), 32'd1);
    drain();
    chk("fullpop_len", 32'(log1.size()), 32'd5);
    chk_log("fullpop_ev0", 1, 0, 5'h04);
    chk_log("fullpop_ev1", 1, 1, 5'h01);
    chk_log("fullpop_ev2", 1, 2, 5'h02);
    chk_log("fullpop_ev3", 1, 3, 5'h03);
    chk_log("fullpop_ev4", 1, 4, 5'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
